// File: rtl/ad7606_cfg_sched_pkg.sv
// Shared types and constants for the AD7606 configuration scheduler.
package ad7606_cfg_sched_pkg;

    // Config byte layout as seen by the AD7606 interface IP.
    typedef struct packed {
        logic [2:0] ch;
        logic [2:0] os;
        logic       stby;
        logic       rng;
    } cfg_t;

    // Oversampling code the IP does not accept; requests carrying it are rejected.
    localparam logic [2:0]  OS_INVALID = 3'b111;

    // Word presented on data_o while in reset.
    localparam logic [15:0] RST_WORD   = 16'h0002;

    typedef enum logic [2:0] {
        ST_INIT_RST,
        ST_INIT_SET,
        ST_LOAD,
        ST_STROBE,
        ST_GAP,
        ST_IDLE,
        ST_REJECT
    } state_e;

    // Counter width able to hold (max duration - 1) for every timed state.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // Word actually written: the synchronized range input replaces the requester's range bit.
    function automatic logic [15:0] cfg_word(input logic [6:0] cfg_hi, input logic rng);
        return {8'h00, cfg_hi, rng};
    endfunction

endpackage

// File: rtl/ad7606_cfg_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps to index 0.
module ad7606_cfg_sched_rr_arbiter
    import ad7606_cfg_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic found;

    // Pick the first request at or above the pointer, otherwise the lowest request overall.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path can leave a value held, which would infer a latch.
        found   = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                found = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
        valid_o = found;
        grant_o = found ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/ad7606_cfg_sched.sv
// AD7606 configuration scheduler: reset-release and default-config sequence,
// then round-robin servicing of config-change requests and range-bit rewrites.
module ad7606_cfg_sched
    import ad7606_cfg_sched_pkg::*;
#(
    parameter int         NREQ       = 2,
    parameter int         RST_CYC    = 4,
    parameter int         SETTLE_CYC = 4,
    parameter int         WR_LEN     = 1,
    parameter int         GAP_CYC    = 2,
    parameter logic [7:0] DEF_CFG    = 8'hE2
) (
    input  logic              led_clk_i,
    input  logic              rst_i,
    input  logic              adc_range_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] cfg_i,
    output logic [NREQ-1:0]   ack_o,
    output logic              err_o,
    output logic              ready_o,
    output logic              wr_data_n_o,
    output logic              rst_ctrl_o,
    output logic [15:0]       data_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = cnt_width(RST_CYC, SETTLE_CYC, WR_LEN, GAP_CYC);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST     = CNT_W'(WR_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);

    // Range synchronizer and edge detect.
    logic range_meta_q, range_s_q, range_q;
    logic range_chg;

    // FSM and datapath state.
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cfg_t             word_q, word_d;
    cfg_t             last_cfg_q, last_cfg_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             is_req_q, is_req_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             range_pend_q, range_pend_d;
    logic [15:0]      data_q, data_d;

    // Arbiter results and the config byte of the winning requester.
    logic [NREQ-1:0]  gnt_oh;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    cfg_t             cfg_arr [NREQ];
    cfg_t             cfg_sel;
    logic [IDX_W-1:0] ptr_next;

    // The stored range bit is never written out; the synchronized input is used instead.
    logic unused_rng;
    assign unused_rng = word_q.rng;

    for (genvar g = 0; g < NREQ; g++) begin : g_cfg
        assign cfg_arr[g] = cfg_t'(cfg_i[8*g +: 8]);
    end

    assign cfg_sel   = cfg_arr[gnt_idx];
    assign ptr_next  = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    assign range_chg = range_s_q ^ range_q;
    assign data_o    = data_q;

    ad7606_cfg_sched_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt_oh),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    // Two-flop synchronizer for the asynchronous range level, plus one stage for change detection.
    always_ff @(posedge led_clk_i or posedge rst_i) begin
        if (rst_i) begin
            range_meta_q <= 1'b0;
            range_s_q    <= 1'b0;
            range_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts by one stage per clock.
            range_meta_q <= adc_range_i;
            range_s_q    <= range_meta_q;
            range_q      <= range_s_q;
        end
    end

    // State register; reset aborts any write in progress and restarts the init sequence.
    always_ff @(posedge led_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT_RST;
            cnt_q        <= '0;
            word_q       <= cfg_t'(DEF_CFG);
            last_cfg_q   <= cfg_t'(DEF_CFG);
            grant_q      <= '0;
            is_req_q     <= 1'b0;
            rr_ptr_q     <= '0;
            range_pend_q <= 1'b0;
            data_q       <= RST_WORD;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            last_cfg_q   <= last_cfg_d;
            grant_q      <= grant_d;
            is_req_q     <= is_req_d;
            rr_ptr_q     <= rr_ptr_d;
            range_pend_q <= range_pend_d;
            data_q       <= data_d;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        word_d       = word_q;
        last_cfg_d   = last_cfg_q;
        grant_d      = grant_q;
        is_req_d     = is_req_q;
        rr_ptr_d     = rr_ptr_q;
        range_pend_d = range_pend_q | (range_chg & (state_q != ST_IDLE));
        data_d       = data_q;

        ack_o        = '0;
        err_o        = 1'b0;
        ready_o      = 1'b0;
        wr_data_n_o  = 1'b1;
        rst_ctrl_o   = 1'b1;

        unique case (state_q)
            ST_INIT_RST: begin
                rst_ctrl_o = 1'b0;
                if (cnt_q == RST_LAST) begin
                    state_d = ST_INIT_SET;
                    cnt_d   = '0;
                end
            end

            ST_INIT_SET: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    word_d   = cfg_t'(DEF_CFG);
                    is_req_d = 1'b0;
                end
            end

            ST_LOAD: begin
                data_d  = cfg_word(word_q[7:1], range_s_q);
                state_d = ST_STROBE;
                cnt_d   = '0;
            end

            ST_STROBE: begin
                wr_data_n_o = 1'b0;
                if (cnt_q == WR_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    // Only requester writes are acknowledged; init and range rewrites are silent.
                    ack_o   = is_req_q ? grant_q : '0;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_IDLE: begin
                ready_o = 1'b1;
                cnt_d   = '0;
                if (range_pend_q || range_chg) begin
                    // A range change re-issues the last accepted config ahead of any request.
                    word_d       = last_cfg_q;
                    is_req_d     = 1'b0;
                    range_pend_d = 1'b0;
                    state_d      = ST_LOAD;
                end else if (gnt_valid) begin
                    grant_d  = gnt_oh;
                    rr_ptr_d = ptr_next;
                    if (cfg_sel.os == OS_INVALID) begin
                        state_d = ST_REJECT;
                    end else begin
                        word_d     = cfg_sel;
                        last_cfg_d = cfg_sel;
                        is_req_d   = 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
            end

            ST_REJECT: begin
                ack_o   = grant_q;
                err_o   = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_INIT_RST;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
